// File: rtl/ace_vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ace_vram_arbiter
// Description : Shares the single-port video RAM between the Z80 and the video
//               fetcher; video fetches always win, the CPU is stalled via
//               cpu_wait. Optional macro ACE_CONTENTION_EN blocks CPU access
//               for the whole active display.
// Revision    : 1.0 - initial release
// ============================================================================
module ace_vram_arbiter #(
    parameter int AW = 10,
    parameter int DW = 8
) (
    input  logic          clk50mhz,
    input  logic          reset,
    input  logic          vid_active,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_ack,
    output logic [DW-1:0] vid_data,
    output logic          vid_ovf,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_din,
    output logic [DW-1:0] cpu_dout,
    output logic          cpu_wait,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_VRD  = 3'd1,
        S_VWT  = 3'd2,
        S_CRD  = 3'd3,
        S_CWT  = 3'd4,
        S_CWR  = 3'd5
    } state_t;

    state_t        r_state;
    logic          r_served;
    logic          r_vid_pend;
    logic [AW-1:0] r_vid_paddr;
    logic          w_grant_ok;
    logic          w_vid_busy;
    logic          w_cpu_go;

`ifdef ACE_CONTENTION_EN
    assign w_grant_ok = ~vid_active;
`else
    // vid_active has no influence when the CPU is interleaved between fetches
    assign w_grant_ok = vid_active | 1'b1;
`endif

    assign w_vid_busy = (r_state == S_VRD) || (r_state == S_VWT);
    assign w_cpu_go   = cpu_req & ~r_served & w_grant_ok;
    assign cpu_wait   = cpu_req & ~r_served;

    always_ff @(posedge clk50mhz) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_served    <= 1'b0;
            r_vid_pend  <= 1'b0;
            r_vid_paddr <= '0;
            ram_addr    <= '0;
            ram_we      <= 1'b0;
            ram_din     <= '0;
            vid_ack     <= 1'b0;
            vid_data    <= '0;
            vid_ovf     <= 1'b0;
            cpu_dout    <= '0;
        end else begin
            vid_ack <= 1'b0;
            if (!cpu_req) begin
                r_served <= 1'b0;
            end

            // A strobe during a CPU cycle is parked; a second one is dropped
            if (vid_req) begin
                if (r_vid_pend || w_vid_busy) begin
                    vid_ovf <= 1'b1;
                end else if (r_state != S_IDLE) begin
                    r_vid_pend  <= 1'b1;
                    r_vid_paddr <= vid_addr;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (r_vid_pend) begin
                        ram_addr   <= r_vid_paddr;
                        r_vid_pend <= 1'b0;
                        r_state    <= S_VRD;
                    end else if (vid_req) begin
                        ram_addr <= vid_addr;
                        r_state  <= S_VRD;
                    end else if (w_cpu_go) begin
                        ram_addr <= cpu_addr;
                        if (cpu_we) begin
                            ram_din <= cpu_din;
                            ram_we  <= 1'b1;
                            r_state <= S_CWR;
                        end else begin
                            r_state <= S_CRD;
                        end
                    end
                end
                S_VRD: r_state <= S_VWT;
                S_VWT: begin
                    vid_data <= ram_dout;
                    vid_ack  <= 1'b1;
                    r_state  <= S_IDLE;
                end
                S_CRD: r_state <= S_CWT;
                S_CWT: begin
                    cpu_dout <= ram_dout;
                    r_served <= 1'b1;
                    r_state  <= S_IDLE;
                end
                S_CWR: begin
                    ram_we   <= 1'b0;
                    r_served <= 1'b1;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ace_vram_arbiter.sv
`default_nettype none
// Bench for ace_vram_arbiter: vector table of single accesses, corner sequences,
// and a randomized run scored against a transaction-level memory model.
module tb_ace_vram_arbiter;
    localparam int AW = 10;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          vid_active;
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic          vid_ack;
    logic [DW-1:0] vid_data;
    logic          vid_ovf;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_din;
    logic [DW-1:0] cpu_dout;
    logic          cpu_wait;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    int checks = 0;
    int errors = 0;

    bit   [7:0] mem [1024];
    bit         wv  [1024];
    logic [7:0] ref_mem [1024];

    always #5 clk = ~clk;

    ace_vram_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk50mhz  (clk),
        .reset     (reset),
        .vid_active(vid_active),
        .vid_req   (vid_req),
        .vid_addr  (vid_addr),
        .vid_ack   (vid_ack),
        .vid_data  (vid_data),
        .vid_ovf   (vid_ovf),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_din   (cpu_din),
        .cpu_dout  (cpu_dout),
        .cpu_wait  (cpu_wait),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    function automatic logic [7:0] init_byte(input logic [9:0] a);
        return a[7:0] ^ 8'hF1 ^ {a[9], 6'b0, a[8]};
    endfunction

    // Synchronous single-port RAM, one cycle read latency
    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_din;
            wv[ram_addr]  <= 1'b1;
        end
        ram_dout <= wv[ram_addr] ? mem[ram_addr] : init_byte(ram_addr);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit         vid;
        bit         we;
        logic [9:0] addr;
        logic [7:0] din;
        int         lat;
        logic [7:0] data;
        int         wes;
    } vec_t;

    vec_t vt [9];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, nwe, vlat, clat, waits, nack;
        logic [7:0] got, vd, cd;
        logic [9:0] wa;
        logic [7:0] wd;

        for (int i = 0; i < 1024; i++) ref_mem[i] = init_byte(10'(i));

        vt[0] = '{1'b1, 1'b0, 10'h155, 8'h00, 3, 8'hA5, 0};
        vt[1] = '{1'b0, 1'b1, 10'h020, 8'h3C, 2, 8'h00, 1};
        vt[2] = '{1'b0, 1'b0, 10'h020, 8'h00, 3, 8'h3C, 0};
        vt[3] = '{1'b1, 1'b0, 10'h020, 8'h00, 3, 8'h3C, 0};
        vt[4] = '{1'b0, 1'b0, 10'h3FF, 8'h00, 3, 8'h8F, 0};
        vt[5] = '{1'b1, 1'b0, 10'h000, 8'h00, 3, 8'hF1, 0};
        vt[6] = '{1'b0, 1'b1, 10'h2AA, 8'h96, 2, 8'h00, 1};
        vt[7] = '{1'b0, 1'b0, 10'h2AA, 8'h00, 3, 8'h96, 0};
        vt[8] = '{1'b1, 1'b0, 10'h2AA, 8'h00, 3, 8'h96, 0};

        // Reset with a CPU read already requested
        reset = 1'b1; vid_active = 1'b0; vid_req = 1'b0; vid_addr = '0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h155; cpu_din = '0;
        step(); step(); step();
        chk("rst_cpu_wait", cpu_wait, 1);
        chk("rst_vid_ack", vid_ack, 0);
        chk("rst_vid_data", vid_data, 0);
        chk("rst_vid_ovf", vid_ovf, 0);
        chk("rst_cpu_dout", cpu_dout, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_din", ram_din, 0);
        reset = 1'b0;
        lat = 99; got = '0;
        for (int n = 1; n <= 8 && lat == 99; n++) begin
            step();
            if (!cpu_wait) begin lat = n; got = cpu_dout; end
        end
        chk("rst_rel_lat", lat, 3);
        chk("rst_rel_data", got, 8'hA5);
        cpu_req = 1'b0;
        step(); step();

        // Vector table: one access at a time from idle
        for (int i = 0; i < 9; i++) begin
            lat = 99; nwe = 0; got = '0; wa = '0; wd = '0;
            if (vt[i].vid) begin
                vid_req = 1'b1; vid_addr = vt[i].addr;
            end else begin
                cpu_req = 1'b1; cpu_we = vt[i].we; cpu_addr = vt[i].addr; cpu_din = vt[i].din;
            end
            for (int n = 1; n <= 10 && lat == 99; n++) begin
                step();
                vid_req = 1'b0;
                if (ram_we) begin nwe++; wa = ram_addr; wd = ram_din; end
                if (vt[i].vid && vid_ack) begin lat = n; got = vid_data; end
                if (!vt[i].vid && !cpu_wait) begin lat = n; got = cpu_dout; end
            end
            cpu_req = 1'b0;
            step(); if (ram_we) nwe++;
            step(); if (ram_we) nwe++;
            chk($sformatf("vec%0d_lat", i), lat, vt[i].lat);
            chk($sformatf("vec%0d_we_cycles", i), nwe, vt[i].wes);
            if (vt[i].we) begin
                chk($sformatf("vec%0d_wr_addr", i), wa, vt[i].addr);
                chk($sformatf("vec%0d_wr_data", i), wd, vt[i].din);
                ref_mem[vt[i].addr] = vt[i].din;
            end else begin
                chk($sformatf("vec%0d_rd_data", i), got, vt[i].data);
            end
        end

        // Video and CPU read in the same cycle: video first
        vid_req = 1'b1; vid_addr = 10'h155;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h3FF;
        vlat = 99; clat = 99; vd = '0; cd = '0;
        for (int n = 1; n <= 12; n++) begin
            step();
            vid_req = 1'b0;
            if (vid_ack && vlat == 99) begin vlat = n; vd = vid_data; end
            if (!cpu_wait && clat == 99) begin clat = n; cd = cpu_dout; end
        end
        chk("both_vid_lat", vlat, 3);
        chk("both_vid_data", vd, 8'hA5);
        chk("both_cpu_lat", clat, 6);
        chk("both_cpu_data", cd, ref_mem[10'h3FF]);
        cpu_req = 1'b0;
        step(); step();

        // CPU request held through active display
        vid_active = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h155;
        waits = 0; clat = 99;
        for (int n = 1; n <= 100; n++) begin
            step();
            if (cpu_wait) waits++;
            else if (clat == 99) clat = n;
        end
`ifdef ACE_CONTENTION_EN
        chk("cont_held_cycles", waits, 100);
        vid_active = 1'b0;
        clat = 99;
        for (int n = 1; n <= 8 && clat == 99; n++) begin
            step();
            if (!cpu_wait) clat = n;
        end
        chk("cont_release_lat", clat, 3);
`else
        chk("nocont_lat", clat, 3);
        chk("nocont_waits", waits, 2);
`endif
        chk("cont_data", cpu_dout, 8'hA5);
        vid_active = 1'b0; cpu_req = 1'b0;
        step(); step();

        // Second strobe two cycles after the first: overflow, first fetch kept
        vid_req = 1'b1; vid_addr = 10'h001;
        step(); vid_req = 1'b0;
        step(); vid_req = 1'b1; vid_addr = 10'h002;
        nack = 0; vlat = 99; vd = '0;
        for (int n = 3; n <= 14; n++) begin
            step();
            vid_req = 1'b0;
            if (n == 3) chk("ovf_set", vid_ovf, 1);
            if (vid_ack) begin
                nack++;
                if (vlat == 99) begin vlat = n; vd = vid_data; end
            end
        end
        chk("ovf_sticky", vid_ovf, 1);
        chk("ovf_ack_count", nack, 1);
        chk("ovf_first_lat", vlat, 3);
        chk("ovf_first_data", vd, ref_mem[10'h001]);
        reset = 1'b1;
        step(); step();
        chk("ovf_reset_clear", vid_ovf, 0);
        reset = 1'b0;
        step();

        // Randomized traffic scored against a transaction-level model
        begin
            int vlast, cstart, gap, we_run, t, vl;
            int vq_t [$];
            logic [7:0] vq_d [$];
            logic [7:0] d;
            logic [9:0] ca;
            logic [7:0] cdin;
            bit cbusy, cw;
            vlast = -100; cstart = 0; gap = 0; we_run = 0; cbusy = 1'b0; cw = 1'b0;
            ca = '0; cdin = '0;
            for (int cyc = 0; cyc < 4000; cyc++) begin
                step();
                vid_req = 1'b0;
                if (ram_we) begin
                    we_run++;
                    chk("rnd_we_pulse", int'(we_run <= 1), 1);
                end else begin
                    we_run = 0;
                end
                if (vid_ack) begin
                    if (vq_t.size() == 0) begin
                        chk("rnd_vid_spurious", vq_t.size(), 1);
                    end else begin
                        t = vq_t.pop_front();
                        d = vq_d.pop_front();
                        vl = cyc - t;
                        chk("rnd_vid_data", vid_data, d);
                        chk("rnd_vid_lat_in_3_6", int'(vl >= 3 && vl <= 6), 1);
                    end
                end
                if (cbusy) begin
                    if (!cpu_wait) begin
                        chk("rnd_cpu_lat_le_10", int'((cyc - cstart) <= 10), 1);
                        if (cw) ref_mem[ca] = cdin;
                        else chk("rnd_cpu_data", cpu_dout, ref_mem[ca]);
                        cbusy = 1'b0; cpu_req = 1'b0;
                        gap = int'($urandom_range(0, 2));
                    end else if ((cyc - cstart) > 20) begin
                        chk("rnd_cpu_timeout", cyc - cstart, 0);
                        cbusy = 1'b0; cpu_req = 1'b0; gap = 2;
                    end
                end else if (gap > 0) begin
                    gap--;
                end else if (cyc < 3950 && $urandom_range(0, 2) == 0) begin
                    cw = bit'($urandom_range(0, 1));
                    ca = cw ? 10'($urandom_range(0, 511)) : 10'($urandom_range(0, 1023));
                    cdin = 8'($urandom_range(0, 255));
                    cpu_we = cw; cpu_addr = ca; cpu_din = cdin; cpu_req = 1'b1;
                    cbusy = 1'b1; cstart = cyc;
                end
                if (cyc < 3950 && (cyc - vlast) >= 6 && $urandom_range(0, 3) == 0) begin
                    vid_addr = 10'h200 | 10'($urandom_range(0, 511));
                    vid_req = 1'b1;
                    vq_t.push_back(cyc);
                    vq_d.push_back(ref_mem[vid_addr]);
                    vlast = cyc;
                end
            end
            chk("rnd_vid_drained", vq_t.size(), 0);
            chk("rnd_cpu_idle", int'(cbusy), 0);
            chk("rnd_no_ovf", vid_ovf, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
